pwm_duty_sequencer: RTL and testbench

Sequencer that owns the duty command of the PWM generator. It accepts duty-cycle requests from the control/offset path over a valid/ready handshake and soft-starts the output after enable. It slew-limits every change and commits new duty values only at PWM period boundaries, so the generator never sees a mid-period jump. It also forces the duty to zero on fault or disable.

---
 rtl/pwm_duty_sequencer_if.sv | 21 ++
 rtl/pwm_duty_sequencer.sv | 128 ++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_sequencer_if.sv
// Request channel carrying target duty values into the PWM duty sequencer.
// The requester drives valid/duty; the sequencer answers with ready.
interface pwm_duty_sequencer_if #(
    parameter int TP = 8
);
    logic          req_valid;
    logic [TP-1:0] req_duty;
    logic          req_ready;

    modport master (
        output req_valid,
        output req_duty,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_duty,
        output req_ready
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Owns the PWM duty command: soft-start after enable, slew-limited changes
// committed only at period boundaries, and forced zero on fault or disable.
module pwm_duty_sequencer #(
    parameter int TP      = 8,
    parameter int N_bit   = 14,
    parameter int PERIOD  = 10000,
    parameter int STEP    = 4,
    parameter int SS_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fault,
    pwm_duty_sequencer_if.slave   req,
    output logic [TP-1:0]         duty_out,
    output logic                  period_tick,
    output logic [1:0]            state_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SOFT_START = 2'd1,
        RUN        = 2'd2,
        FAULT      = 2'd3
    } state_t;

    localparam logic [N_bit-1:0] LAST_COUNT = N_bit'(PERIOD - 1);
    localparam logic [TP:0]      SS_INC     = (TP + 1)'(SS_STEP);
    localparam logic [TP:0]      RUN_INC    = (TP + 1)'(STEP);

    state_t           state_q, state_d;
    logic [N_bit-1:0] count_q, count_d;
    logic [TP-1:0]    duty_q, duty_d;
    logic [TP-1:0]    target_q, target_d;

    logic             lastCount;
    logic             accept;
    logic [TP:0]      dutyExt, targetExt;
    logic [TP:0]      ssSum, runUp, runDown, delta;
    logic [TP-1:0]    ssNext, runNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            duty_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            duty_q   <= duty_d;
            target_q <= target_d;
        end
    end

    assign lastCount = (count_q == LAST_COUNT);
    assign count_d   = lastCount ? '0 : count_q + N_bit'(1);

    assign req.req_ready = (state_q != FAULT) && !rst;
    assign accept        = req.req_valid && req.req_ready;
    assign target_d      = accept ? req.req_duty : target_q;

    // One extra bit keeps sums and differences from wrapping before the clamp to target.
    always_comb begin
        dutyExt   = {1'b0, duty_q};
        targetExt = {1'b0, target_q};
        ssSum     = dutyExt + SS_INC;
        ssNext    = (ssSum > targetExt) ? target_q : ssSum[TP-1:0];
        runUp     = dutyExt + RUN_INC;
        runDown   = dutyExt - RUN_INC;
        if (targetExt >= dutyExt) begin
            delta   = targetExt - dutyExt;
            runNext = (delta > RUN_INC) ? runUp[TP-1:0] : target_q;
        end else begin
            delta   = dutyExt - targetExt;
            runNext = (delta > RUN_INC) ? runDown[TP-1:0] : target_q;
        end
    end

    // Fault outranks disable, which outranks the per-period duty update.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        if (fault) begin
            state_d = FAULT;
            duty_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (en) state_d = SOFT_START;
                end
                SOFT_START: begin
                    if (!en) begin
                        state_d = IDLE;
                        duty_d  = '0;
                    end else if (lastCount) begin
                        duty_d = ssNext;
                        if (ssNext == target_q) state_d = RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_d = IDLE;
                        duty_d  = '0;
                    end else if (lastCount) begin
                        duty_d = runNext;
                    end
                end
                FAULT: begin
                    duty_d = '0;
                    if (!en) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    assign duty_out    = duty_q;
    assign state_out   = state_q;
    assign period_tick = lastCount && !rst;
    assign busy        = ((state_q == SOFT_START) || (state_q == RUN)) && (duty_q != target_q);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer with a short period so every
// ramp, slew, fault and reset corner finishes in a few thousand cycles.
module tb_pwm_duty_sequencer;

    localparam int TP   = 8;
    localparam int PER  = 16;
    localparam int STEP = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SS    = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fault;
    logic [TP-1:0] dutyOut;
    logic          periodTick;
    logic [1:0]    stateOut;
    logic          busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int tbCount     = 0;

    pwm_duty_sequencer_if #(.TP(TP)) reqIf();

    pwm_duty_sequencer #(
        .TP(TP), .N_bit(14), .PERIOD(PER), .STEP(STEP), .SS_STEP(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fault       (fault),
        .req         (reqIf.slave),
        .duty_out    (dutyOut),
        .period_tick (periodTick),
        .state_out   (stateOut),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       en;
        logic       fault;
        logic       valid;
        logic [7:0] duty;
        int         ticks;
        logic [7:0] expDuty;
        logic [1:0] expState;
        logic       expBusy;
        logic       expReady;
    } vec_t;

    vec_t vecs[$];

    task automatic checkVal(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input int expDuty, input int expState,
                               input int expBusy, input int expReady);
        checkVal({name, "/duty"}, int'(dutyOut), expDuty);
        checkVal({name, "/state"}, int'(stateOut), expState);
        checkVal({name, "/busy"}, int'(busy), expBusy);
        checkVal({name, "/ready"}, int'(reqIf.req_ready), expReady);
    endtask

    // The bench keeps its own period counter and checks period_tick against it every cycle.
    task automatic stepCycle();
        logic rstAtEdge;
        rstAtEdge = rst;
        @(posedge clk);
        #1;
        if (rstAtEdge) tbCount = 0;
        else tbCount = (tbCount == PER - 1) ? 0 : tbCount + 1;
        checkVal("period_tick", int'(periodTick), int'(!rst && (tbCount == PER - 1)));
    endtask

    task automatic stepTo(input int cnt);
        int n;
        n = 0;
        while (tbCount != cnt && n < PER) begin
            stepCycle();
            n++;
        end
    endtask

    task automatic passTick();
        stepTo(PER - 1);
        stepCycle();
    endtask

    task automatic request(input int d);
        reqIf.req_valid = 1'b1;
        reqIf.req_duty  = 8'(d);
        stepCycle();
        reqIf.req_valid = 1'b0;
    endtask

    task automatic rampTo(input string name, input int target, input int maxTicks);
        int n;
        request(target);
        n = 0;
        while (int'(dutyOut) != target && n < maxTicks) begin
            passTick();
            n++;
        end
        checkVal(name, int'(dutyOut), target);
    endtask

    task automatic applyStimulus(input vec_t v);
        en    = v.en;
        fault = v.fault;
        if (v.valid) request(int'(v.duty));
        else if (v.ticks == 0) stepCycle();
        repeat (v.ticks) passTick();
    endtask

    initial begin
        int c;

        rst = 1'b1; en = 1'b0; fault = 1'b0;
        reqIf.req_valid = 1'b0;
        reqIf.req_duty  = '0;

        vecs.push_back('{"ss_req",     1, 0, 1, 8'd5,  0, 8'd0,  S_SS,  1, 1});
        vecs.push_back('{"ss_tick1",   1, 0, 0, 8'd0,  1, 8'd1,  S_SS,  1, 1});
        vecs.push_back('{"ss_tick2",   1, 0, 0, 8'd0,  1, 8'd2,  S_SS,  1, 1});
        vecs.push_back('{"ss_tick3",   1, 0, 0, 8'd0,  1, 8'd3,  S_SS,  1, 1});
        vecs.push_back('{"ss_tick4",   1, 0, 0, 8'd0,  1, 8'd4,  S_SS,  1, 1});
        vecs.push_back('{"ss_tick5",   1, 0, 0, 8'd0,  1, 8'd5,  S_RUN, 0, 1});
        vecs.push_back('{"run_req10",  1, 0, 1, 8'd10, 0, 8'd5,  S_RUN, 1, 1});
        vecs.push_back('{"run_at10",   1, 0, 0, 8'd0,  2, 8'd10, S_RUN, 0, 1});
        vecs.push_back('{"slew_req30", 1, 0, 1, 8'd30, 0, 8'd10, S_RUN, 1, 1});
        vecs.push_back('{"slew_14",    1, 0, 0, 8'd0,  1, 8'd14, S_RUN, 1, 1});
        vecs.push_back('{"slew_18",    1, 0, 0, 8'd0,  1, 8'd18, S_RUN, 1, 1});
        vecs.push_back('{"slew_22",    1, 0, 0, 8'd0,  1, 8'd22, S_RUN, 1, 1});
        vecs.push_back('{"slew_26",    1, 0, 0, 8'd0,  1, 8'd26, S_RUN, 1, 1});
        vecs.push_back('{"slew_30",    1, 0, 0, 8'd0,  1, 8'd30, S_RUN, 0, 1});
        vecs.push_back('{"slew_down28",1, 0, 1, 8'd28, 1, 8'd28, S_RUN, 0, 1});

        stepCycle();
        stepCycle();
        checkOutput("reset_hold", 0, S_IDLE, 0, 0);
        rst = 1'b0;
        #1;
        checkOutput("after_release", 0, S_IDLE, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, int'(vecs[i].expDuty), int'(vecs[i].expState),
                        int'(vecs[i].expBusy), int'(vecs[i].expReady));
        end

        // Two requests inside one period: only the later one matters at the tick.
        stepTo(3);
        request(50);
        checkVal("mid_hold_a", int'(dutyOut), 28);
        stepTo(9);
        request(60);
        checkVal("mid_hold_b", int'(dutyOut), 28);
        passTick();
        checkVal("mid_first_tick", int'(dutyOut), 32);
        repeat (5) passTick();
        checkVal("mid_past_50", int'(dutyOut), 52);
        repeat (2) passTick();
        checkOutput("mid_settled", 60, S_RUN, 0, 1);

        // Request landing on the tick cycle itself uses the old target for that tick.
        stepTo(PER - 1);
        request(70);
        checkOutput("coincide_old_target", 60, S_RUN, 1, 1);
        passTick();
        checkVal("coincide_next_tick", int'(dutyOut), 64);

        rampTo("fault_setup_40", 40, 10);
        stepTo(7);
        fault = 1'b1;
        stepCycle();
        checkOutput("fault_entry", 0, S_FAULT, 0, 0);
        fault = 1'b0;
        request(99);
        repeat (20) stepCycle();
        checkOutput("fault_sticky_en1", 0, S_FAULT, 0, 0);
        en = 1'b0;
        stepCycle();
        checkOutput("fault_exit_idle", 0, S_IDLE, 0, 1);

        en = 1'b1;
        stepCycle();
        checkOutput("restart_ss", 0, S_SS, 1, 1);
        repeat (3) passTick();
        checkVal("restart_ramp3", int'(dutyOut), 3);
        en = 1'b0;
        stepCycle();
        checkOutput("disable_in_ss", 0, S_IDLE, 0, 1);
        en = 1'b1;
        stepCycle();
        checkOutput("reenable_ss", 0, S_SS, 1, 1);
        c = 0;
        while (stateOut != S_RUN && c < 45) begin
            passTick();
            c++;
        end
        checkOutput("retained_target_40", 40, S_RUN, 0, 1);

        request(100);
        repeat (2) passTick();
        checkVal("pre_reset_ramp", int'(dutyOut), 48);
        stepTo(5);
        rst = 1'b1;
        en  = 1'b0;
        stepCycle();
        checkOutput("mid_ramp_reset", 0, S_IDLE, 0, 0);
        checkVal("mid_ramp_reset/tick", int'(periodTick), 0);
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("reset_released", 0, S_IDLE, 0, 1);
        c = 1;
        while (!periodTick && c < 3 * PER) begin
            stepCycle();
            c++;
        end
        checkVal("first_tick_cycle", c, PER);
        stepCycle();

        // Target was cleared by reset, so soft start ends on its first tick.
        en = 1'b1;
        stepCycle();
        checkOutput("zero_target_ss", 0, S_SS, 0, 1);
        passTick();
        checkOutput("zero_target_run", 0, S_RUN, 0, 1);

        rampTo("sat_setup_253", 253, 70);
        request(255);
        passTick();
        checkOutput("sat_255", 255, S_RUN, 0, 1);
        rampTo("sat_setup_2", 2, 70);
        request(0);
        passTick();
        checkOutput("sat_zero", 0, S_RUN, 0, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
